timer_ctrl: RTL and testbench

Control FSM for the countdown timer datapath (packed {hr,min,sec,cs} counter). Converts start/stop and clear button levels into edge-triggered commands. Generates the 100 Hz count-enable tick, holds the preset load value and drives the counter's load strobe. Detects expiry from the datapath zero flag and raises a timed alarm. Sits between the debounced button inputs and the timer datapath.

---
 rtl/timer_pkg.sv | 36 +++
 rtl/timer_ctrl_tick_prescaler.sv | 37 +++
 rtl/timer_ctrl.sv | 126 ++++++++++++
 tb/tb_timer_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer control path.
// Time values are packed as {hr, min, sec, cs}.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned HR_W   = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned CS_W   = 7;
    localparam int unsigned TIME_W = HR_W + MIN_W + SEC_W + CS_W;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] mn;
        logic [SEC_W-1:0] sec;
        logic [CS_W-1:0]  cs;
    } time_t;

    localparam logic [TIME_W-1:0] PRESET_DEFAULT = {5'd23, 6'd59, 6'd59, 7'd99};

    function automatic logic preset_valid(input time_t t);
        return (t.hr <= HR_MAX) && (t.mn <= MIN_MAX) && (t.sec <= SEC_MAX) && (t.cs <= CS_MAX);
    endfunction

endpackage

// File: rtl/timer_ctrl_tick_prescaler.sv
// Free-running divider producing the count-enable tick; clr zeroes the phase,
// hold freezes it so a paused timer resumes with the same phase.
module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Control FSM for the countdown timer: button edge detection, 100 Hz tick,
// preset register with range check, and the expiry alarm.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned TICK_HZ     = 100,
    parameter int unsigned ALARM_TICKS = 300
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              time_zero,
    input  logic              preset_we,
    input  logic [TIME_W-1:0] preset_in,
    output logic              cnt_en,
    output logic              cnt_load,
    output logic [TIME_W-1:0] load_value,
    output logic              running,
    output logic              alarm,
    output logic              preset_err,
    output logic [1:0]        state
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned ACW = $clog2(ALARM_TICKS + 1);
    localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_TICKS - 1);

    state_e            state_q;
    logic [TIME_W-1:0] preset_q;
    logic [ACW-1:0]    alarm_cnt_q;
    logic              start_q, clear_q;
    logic              cnt_en_q, cnt_load_q, alarm_q, preset_err_q, running_q;

    logic start_evt, clr_evt, preset_ok, tick;

    assign start_evt = start_stop & ~start_q;
    assign clr_evt   = clear & ~clear_q;
    assign preset_ok = preset_valid(time_t'(preset_in)) && (state_q != StRun);

    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_evt || (state_q == StIdle)),
        .hold (state_q == StPause),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            preset_q     <= PRESET_DEFAULT;
            alarm_cnt_q  <= '0;
            start_q      <= 1'b0;
            clear_q      <= 1'b0;
            cnt_en_q     <= 1'b0;
            cnt_load_q   <= 1'b1;  // datapath picks up the preset right after reset
            alarm_q      <= 1'b0;
            preset_err_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            start_q      <= start_stop;
            clear_q      <= clear;
            cnt_en_q     <= tick && (state_q == StRun) && !time_zero;
            cnt_load_q   <= clr_evt;
            preset_err_q <= preset_we && !preset_ok;
            if (preset_we && preset_ok) begin
                preset_q <= preset_in;
            end

            if (clr_evt) begin
                state_q   <= StIdle;
                running_q <= 1'b0;
                alarm_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_evt && !time_zero) begin
                            state_q   <= StRun;
                            running_q <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (time_zero) begin
                            state_q     <= StDone;
                            running_q   <= 1'b0;
                            alarm_q     <= 1'b1;
                            alarm_cnt_q <= '0;
                        end else if (start_evt) begin
                            state_q   <= StPause;
                            running_q <= 1'b0;
                        end
                    end
                    StPause: begin
                        if (start_evt) begin
                            state_q   <= StRun;
                            running_q <= 1'b1;
                        end
                    end
                    StDone: begin
                        // Either the alarm has sounded its full length or it is acknowledged
                        if (start_evt || (tick && (alarm_cnt_q == ALARM_LAST))) begin
                            state_q <= StIdle;
                            alarm_q <= 1'b0;
                        end else if (tick) begin
                            alarm_cnt_q <= alarm_cnt_q + ACW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cnt_en     = cnt_en_q;
    assign cnt_load   = cnt_load_q;
    assign load_value = preset_q;
    assign running    = running_q;
    assign alarm      = alarm_q;
    assign preset_err = preset_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: a cycle-level reference model pushes the
// expected outputs, a monitor pops and compares them on the falling edge.
module tb_timer_ctrl;

    localparam int DIV = 10;
    localparam int AT  = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start_stop = 1'b0, clear = 1'b0, time_zero = 1'b0;
    logic        preset_we = 1'b0;
    logic [23:0] preset_in = '0;
    logic        cnt_en, cnt_load, running, alarm, preset_err;
    logic [23:0] load_value;
    logic [1:0]  state;

    always #5 clk = ~clk;

    timer_ctrl #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .ALARM_TICKS(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .clear     (clear),
        .time_zero (time_zero),
        .preset_we (preset_we),
        .preset_in (preset_in),
        .cnt_en    (cnt_en),
        .cnt_load  (cnt_load),
        .load_value(load_value),
        .running   (running),
        .alarm     (alarm),
        .preset_err(preset_err),
        .state     (state)
    );

    typedef struct {
        int          st;
        bit          run;
        bit          alm;
        bit          en;
        bit          ld;
        bit          err;
        logic [23:0] lv;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    bit   pend_v = 0;
    int   n_cmp = 0, n_bad = 0;

    // Reference model state
    int          m_st, m_phase, m_acnt;
    bit          m_ss_prev, m_cl_prev;
    logic [23:0] m_preset;

    // Stimulus levels held between cycles
    bit g_r = 1, g_ss = 0, g_cl = 0, g_tz = 0;

    function automatic logic [23:0] tv(input int h, input int m, input int s, input int c);
        return {h[4:0], m[5:0], s[5:0], c[6:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(output exp_t e);
        bit se, ce, tick;
        int hr, mn, sc, cs, nxt;
        e.err = 0;
        e.en  = 0;
        e.ld  = 0;
        if (reset) begin
            m_st = S_IDLE; m_phase = 0; m_acnt = 0;
            m_ss_prev = 0; m_cl_prev = 0;
            m_preset = tv(23, 59, 59, 99);
            e.ld = 1;
        end else begin
            se = start_stop && !m_ss_prev;
            ce = clear && !m_cl_prev;
            m_ss_prev = start_stop;
            m_cl_prev = clear;
            tick = (m_phase == DIV - 1);
            e.en = tick && (m_st == S_RUN) && !time_zero;
            e.ld = ce;
            if (preset_we) begin
                hr = int'(preset_in >> 19);
                mn = int'(preset_in >> 13) % 64;
                sc = int'(preset_in >> 7) % 64;
                cs = int'(preset_in) % 128;
                if (m_st != S_RUN && hr <= 23 && mn <= 59 && sc <= 59 && cs <= 99)
                    m_preset = preset_in;
                else
                    e.err = 1;
            end
            nxt = m_st;
            if (ce) nxt = S_IDLE;
            else case (m_st)
                S_IDLE:  if (se && !time_zero) nxt = S_RUN;
                S_RUN: begin
                    if (time_zero) begin nxt = S_DONE; m_acnt = 0; end
                    else if (se) nxt = S_PAUSE;
                end
                S_PAUSE: if (se) nxt = S_RUN;
                default: begin
                    if (se || (tick && m_acnt == AT - 1)) nxt = S_IDLE;
                    else if (tick) m_acnt++;
                end
            endcase
            // Phase advances on the state in force during this cycle
            if (ce || m_st == S_IDLE) m_phase = 0;
            else if (m_st != S_PAUSE) m_phase = (m_phase + 1) % DIV;
            m_st = nxt;
        end
        e.st  = m_st;
        e.run = (m_st == S_RUN);
        e.alm = (m_st == S_DONE);
        e.lv  = m_preset;
    endtask

    task automatic drive(input bit we, input logic [23:0] pin);
        exp_t e;
        @(posedge clk);
        if (pend_v) exp_q.push_back(pend);
        #1;
        reset = g_r; start_stop = g_ss; clear = g_cl; time_zero = g_tz;
        preset_we = we; preset_in = pin;
        model_step(e);
        pend = e;
        pend_v = 1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) drive(0, 24'h0);
    endtask

    task automatic pulse_ss();
        g_ss = 1; cyc(1); g_ss = 0; cyc(1);
    endtask

    task automatic pulse_cl();
        g_cl = 1; cyc(1); g_cl = 0; cyc(1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state", 32'(state), e.st);
                check("running", 32'(running), 32'(e.run));
                check("alarm", 32'(alarm), 32'(e.alm));
                check("cnt_en", 32'(cnt_en), 32'(e.en));
                check("cnt_load", 32'(cnt_load), 32'(e.ld));
                check("preset_err", 32'(preset_err), 32'(e.err));
                check("load_value", 32'(load_value), 32'(e.lv));
            end
        end
    end

    initial begin : stimulus
        // Reset, release, idle
        g_r = 1; cyc(2); g_r = 0; cyc(5);
        // Start and hold the button: one event only
        g_ss = 1; cyc(50); g_ss = 0; cyc(30);
        // Pause mid-phase, long pause, resume
        pulse_cl(); pulse_ss(); cyc(2);
        pulse_ss(); cyc(100); pulse_ss(); cyc(20);
        // Expiry with full alarm, then acknowledged alarm
        g_tz = 1; cyc(40); g_tz = 0;
        pulse_ss(); cyc(7); g_tz = 1; cyc(5); pulse_ss(); cyc(3); g_tz = 0;
        // Start while time_zero in idle must not run
        g_tz = 1; pulse_ss(); cyc(3); g_tz = 0;
        // Clear and start together in RUN
        pulse_ss(); cyc(5); g_cl = 1; g_ss = 1; cyc(1); g_cl = 0; g_ss = 0; cyc(5);
        // Preset writes: valid in IDLE, rejected in RUN, out-of-range fields
        drive(1, tv(1, 2, 3, 4)); cyc(2);
        pulse_ss(); drive(1, tv(5, 6, 7, 8)); cyc(2); pulse_cl();
        drive(1, tv(24, 0, 0, 0)); drive(1, tv(0, 60, 0, 0));
        drive(1, tv(0, 0, 60, 0)); drive(1, tv(0, 0, 0, 100));
        drive(1, tv(23, 59, 59, 99)); cyc(2); pulse_cl(); cyc(3);
        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [23:0] pin;
            bit we;
            g_r = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 11) == 0) g_ss = ~g_ss;
            if ($urandom_range(0, 29) == 0) g_cl = ~g_cl;
            if ($urandom_range(0, 39) == 0) g_tz = ~g_tz;
            we = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 1) == 0)
                pin = tv($urandom_range(0, 23), $urandom_range(0, 59),
                         $urandom_range(0, 59), $urandom_range(0, 99));
            else
                pin = 24'($urandom());
            drive(we, pin);
        end
        g_r = 0;
        cyc(1);
        @(posedge clk);
        if (pend_v) exp_q.push_back(pend);
        pend_v = 0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
